// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

  localparam int NUM_MASTERS     = 2;
  localparam int OUTSTANDING_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FLUSH = 2'd2
  } arb_state_e;

  // One bit selects between the core (0) and the secondary master (1).
  typedef logic mst_idx_t;

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts cycles while enabled and not cleared, and pulses
// fire_o for one cycle when the count reaches TIMEOUT. TIMEOUT = 0 disables it.
module wb_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  input  logic clear_i,
  input  logic tick_i,
  output logic fire_o
);

  localparam bit ACTIVE = (TIMEOUT > 0);
  localparam int CW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // fire is registered, so it is raised on the edge that moves the count
  // from TIMEOUT-1 to TIMEOUT; both become visible in the same cycle.
  localparam logic [CW-1:0] LAST = ACTIVE ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt_q;
  logic          fire_q;
  logic          counting;

  assign counting = ACTIVE && enable_i && !clear_i && tick_i;

  // Cycle counter and single-cycle fire pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      fire_q <= 1'b0;
    end else begin
      fire_q <= 1'b0;
      if (!enable_i || clear_i) begin
        cnt_q <= '0;
      end else if (counting) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == LAST) fire_q <= 1'b1;
      end
    end
  end

  assign fire_o = fire_q;

endmodule

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter with round-robin tie-break, outstanding
// transaction tracking and a watchdog that flushes a hung slave with errors.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS-1:0][3:0]       m_sel_i,
  input  logic [NUM_MASTERS-1:0][31:0]      m_adr_i,
  input  logic [NUM_MASTERS-1:0][31:0]      m_dat_i,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_stall_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [31:0]                       m_dat_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [3:0]                        s_sel_o,
  output logic [31:0]                       s_adr_o,
  output logic [31:0]                       s_dat_o,
  input  logic                              s_ack_i,
  input  logic                              s_stall_i,
  input  logic [31:0]                       s_dat_i,
  output logic                              timeout_o
);

  arb_state_e state_q, state_d;
  mst_idx_t   owner_q, owner_d;
  mst_idx_t   last_q,  last_d;
  logic [3:0] out_q,   out_d;
  logic       accepted;
  logic       wd_fire;
  logic       fire;

  localparam logic [3:0] OUT_MAX = 4'(OUTSTANDING_MAX);

  assign accepted  = (state_q == ST_BUSY) && s_stb_o && !s_stall_i;
  assign fire      = wd_fire && (state_q == ST_BUSY);
  assign timeout_o = fire;

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (state_q == ST_BUSY),
    .clear_i  (s_ack_i || (out_q == 4'd0)),
    .tick_i   (1'b1),
    .fire_o   (wd_fire)
  );

  // Next-state: grant, release, outstanding tracking and flush sequencing.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          state_d = ST_BUSY;
          // Tie goes to whoever did not own the bus last.
          owner_d = (&m_cyc_i) ? ~last_q : m_cyc_i[1];
          out_d   = 4'd0;
        end
      end
      ST_BUSY: begin
        if (!m_cyc_i[owner_q]) begin
          // Owner released (possibly with transfers still in flight).
          state_d = ST_IDLE;
          last_d  = owner_q;
          out_d   = 4'd0;
        end else begin
          if (accepted && !s_ack_i && out_q != OUT_MAX) out_d = out_q + 4'd1;
          else if (!accepted && s_ack_i && out_q != 4'd0) out_d = out_q - 4'd1;
          if (fire) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // One error-ack per cycle; the last one retires the flush.
        if (out_q <= 4'd1) begin
          out_d = 4'd0;
          if (m_cyc_i[owner_q]) begin
            state_d = ST_BUSY;
          end else begin
            state_d = ST_IDLE;
            last_d  = owner_q;
          end
        end else begin
          out_d = out_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      out_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      out_q   <= out_d;
    end
  end

  // Bus muxing; everything is qualified by the registered state so reset
  // silences both sides immediately.
  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_sel_o   = 4'h0;
    s_adr_o   = 32'h0;
    s_dat_o   = 32'h0;
    m_ack_o   = '0;
    m_err_o   = '0;
    m_stall_o = '1;
    m_dat_o   = 32'h0;
    case (state_q)
      ST_BUSY: begin
        s_cyc_o            = m_cyc_i[owner_q];
        s_stb_o            = m_stb_i[owner_q];
        s_we_o             = m_we_i[owner_q];
        s_sel_o            = m_sel_i[owner_q];
        s_adr_o            = m_adr_i[owner_q];
        s_dat_o            = m_dat_i[owner_q];
        m_stall_o[owner_q] = s_stall_i;
        m_ack_o[owner_q]   = s_ack_i;
        m_dat_o            = s_dat_i;
      end
      ST_FLUSH: begin
        // Slave responses are dropped here; the owner only sees error-acks.
        m_ack_o[owner_q] = (out_q != 4'd0);
        m_err_o[owner_q] = (out_q != 4'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with the watchdog shortened to 8 cycles.
module tb_wb_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       m_cyc_i, m_stb_i, m_we_i;
  logic [1:0][3:0]  m_sel_i;
  logic [1:0][31:0] m_adr_i, m_dat_i;
  logic [1:0]       m_ack_o, m_stall_o, m_err_o;
  logic [31:0]      m_dat_o;
  logic             s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]       s_sel_o;
  logic [31:0]      s_adr_o, s_dat_o;
  logic             s_ack_i, s_stall_i;
  logic [31:0]      s_dat_i;
  logic             timeout_o;

  int n_chk  = 0;
  int n_fail = 0;

  wb_arbiter #(.TIMEOUT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m_cyc_i   (m_cyc_i),
    .m_stb_i   (m_stb_i),
    .m_we_i    (m_we_i),
    .m_sel_i   (m_sel_i),
    .m_adr_i   (m_adr_i),
    .m_dat_i   (m_dat_i),
    .m_ack_o   (m_ack_o),
    .m_stall_o (m_stall_o),
    .m_err_o   (m_err_o),
    .m_dat_o   (m_dat_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_sel_o   (s_sel_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_ack_i   (s_ack_i),
    .s_stall_i (s_stall_i),
    .s_dat_i   (s_dat_i),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_cyc_i   = 2'b00;
    m_stb_i   = 2'b00;
    m_we_i    = 2'b00;
    m_sel_i   = '0;
    m_adr_i   = '0;
    m_dat_i   = '0;
    s_ack_i   = 1'b0;
    s_stall_i = 1'b0;
    s_dat_i   = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [0:6] stb_tab   = 7'b1111000;
  logic [0:6] stall_tab = 7'b0100000;
  logic [0:6] ack_tab   = 7'b0001110;
  int acks, peak, n;
  bit seen;

  initial begin
    // Reset state, with a master already driving the bus.
    rst_n = 1'b0;
    idle_inputs();
    m_cyc_i    = 2'b01;
    m_stb_i    = 2'b01;
    m_adr_i[0] = 32'hA5A5_0000;
    m_sel_i[0] = 4'hF;
    #3;
    chk("rst_s_cyc",   32'(s_cyc_o),   32'd0);
    chk("rst_s_stb",   32'(s_stb_o),   32'd0);
    chk("rst_stall",   32'(m_stall_o), 32'd3);
    chk("rst_ack",     32'(m_ack_o),   32'd0);
    chk("rst_err",     32'(m_err_o),   32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_s_adr",   s_adr_o,        32'h0);
    chk("rst_s_sel",   32'(s_sel_o),   32'd0);
    chk("rst_m_dat",   m_dat_o,        32'h0);
    do_reset();

    // Single read by master 0, slave acks two cycles after the strobe.
    tick();
    m_cyc_i    = 2'b01;
    m_stb_i    = 2'b01;
    m_sel_i[0] = 4'hF;
    m_adr_i[0] = 32'h8000_0000;
    #1;
    chk("rd_grant_lat", 32'(s_cyc_o), 32'd0);
    tick();
    #1;
    chk("rd_s_cyc",   32'(s_cyc_o),   32'd1);
    chk("rd_s_adr",   s_adr_o,        32'h8000_0000);
    chk("rd_stall",   32'(m_stall_o), 32'd2);
    tick();
    m_stb_i = 2'b00;
    #1;
    chk("rd_no_ack",  32'(m_ack_o),   32'd0);
    tick();
    s_ack_i = 1'b1;
    s_dat_i = 32'h1234_5678;
    #1;
    chk("rd_ack",     32'(m_ack_o),   32'd1);
    chk("rd_dat",     m_dat_o,        32'h1234_5678);
    tick();
    s_ack_i = 1'b0;
    m_cyc_i = 2'b00;
    #1;
    chk("rd_ack_end", 32'(m_ack_o),   32'd0);
    chk("rd_drop",    32'(s_cyc_o),   32'd0);
    tick();

    // Tie right after reset: m0 first, one idle cycle, then m1, then m0 again.
    do_reset();
    m_cyc_i = 2'b11;
    tick();
    #1;
    chk("tie1_stall", 32'(m_stall_o), 32'd2);
    chk("tie1_cyc",   32'(s_cyc_o),   32'd1);
    m_cyc_i = 2'b10;
    #1;
    chk("tie1_drop",  32'(s_cyc_o),   32'd0);
    tick();
    #1;
    chk("tie_gap_cyc",   32'(s_cyc_o),   32'd0);
    chk("tie_gap_stall", 32'(m_stall_o), 32'd3);
    tick();
    #1;
    chk("tie2_stall", 32'(m_stall_o), 32'd1);
    chk("tie2_cyc",   32'(s_cyc_o),   32'd1);
    m_cyc_i = 2'b00;
    tick();
    m_cyc_i = 2'b11;
    tick();
    #1;
    chk("tie3_stall", 32'(m_stall_o), 32'd2);
    m_cyc_i = 2'b00;
    tick();

    // Pipelined: three strobes, second one stalled for a cycle.
    m_cyc_i    = 2'b01;
    m_stb_i    = 2'b01;
    m_adr_i[0] = 32'h0000_0100;
    tick();
    acks = 0;
    peak = 0;
    for (int k = 0; k < 7; k++) begin
      m_stb_i[0] = stb_tab[k];
      s_stall_i  = stall_tab[k];
      s_ack_i    = ack_tab[k];
      #1;
      if (k == 1) chk("pipe_stall", 32'(m_stall_o), 32'd3);
      if (m_ack_o[0]) acks++;
      if (int'(dut.out_q) > peak) peak = int'(dut.out_q);
      tick();
    end
    idle_inputs();
    m_cyc_i = 2'b01;
    #1;
    chk("pipe_acks", 32'(acks),      32'd3);
    chk("pipe_peak", 32'(peak),      32'd2);
    chk("pipe_out0", 32'(dut.out_q), 32'd0);
    m_cyc_i = 2'b00;
    tick();

    // Timeout: m1 issues two strobes, slave never answers.
    m_cyc_i    = 2'b10;
    m_stb_i    = 2'b10;
    m_adr_i[1] = 32'h4000_0000;
    tick();
    tick();
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      m_stb_i = 2'b00;
      n++;
      #1;
      if (timeout_o) seen = 1'b1;
    end
    chk("wd_seen",    32'(seen), 32'd1);
    chk("wd_latency", 32'(n),    32'd8);
    for (int f = 0; f < 2; f++) begin
      tick();
      s_ack_i = 1'b1;
      s_dat_i = 32'hDEAD_BEEF;
      #1;
      chk("fl_ack",   32'(m_ack_o),   32'd2);
      chk("fl_err",   32'(m_err_o),   32'd2);
      chk("fl_dat",   m_dat_o,        32'h0);
      chk("fl_cyc",   32'(s_cyc_o),   32'd0);
      chk("fl_stall", 32'(m_stall_o), 32'd3);
      chk("fl_tmo",   32'(timeout_o), 32'd0);
    end
    tick();
    s_ack_i = 1'b0;
    #1;
    chk("fl_done_ack", 32'(m_ack_o), 32'd0);
    chk("fl_done_err", 32'(m_err_o), 32'd0);
    chk("fl_resume",   32'(s_cyc_o), 32'd1);
    m_cyc_i = 2'b00;
    tick();

    // Reset while m0 has one transfer in flight.
    m_cyc_i = 2'b01;
    m_stb_i = 2'b01;
    tick();
    tick();
    m_stb_i = 2'b00;
    #1;
    chk("mid_busy", 32'(s_cyc_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc",   32'(s_cyc_o),   32'd0);
    chk("mid_rst_stall", 32'(m_stall_o), 32'd3);
    s_ack_i = 1'b1;
    #1;
    chk("mid_rst_ack",   32'(m_ack_o),   32'd0);
    tick();
    tick();
    chk("mid_rst_ack2",  32'(m_ack_o),   32'd0);
    chk("mid_rst_out",   32'(dut.out_q), 32'd0);
    rst_n   = 1'b1;
    s_ack_i = 1'b0;
    m_cyc_i = 2'b10;
    #1;
    chk("post_rst_idle", 32'(s_cyc_o),   32'd0);
    tick();
    #1;
    chk("post_rst_cyc",   32'(s_cyc_o),   32'd1);
    chk("post_rst_stall", 32'(m_stall_o), 32'd1);
    m_cyc_i = 2'b00;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
